// File: rtl/core_seq_ctrl.sv
// Multi-cycle fetch / execute / load-store / writeback sequencer for the RV32 core.
// Sole owner of the PC commit strobe (in_valid) and the PC select (pc_single).
module core_seq_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned CNT_W          = 10
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_data,
    output logic [31:0] inst,
    input  logic        dec_jal,
    input  logic        dec_jalr,
    input  logic        dec_branch,
    input  logic        dec_trap,
    input  logic        dec_load,
    input  logic        dec_store,
    input  logic        dec_ebreak,
    input  logic        dec_rd_wen,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    output logic [2:0]  pc_single,
    output logic        in_valid,
    output logic        reg_wen,
    output logic        busy,
    output logic        halted,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE, IF_REQ, IF_WAIT, EX, MEM_REQ, MEM_WAIT, WB, HALT
    } state_t;

    // Last count value that still allows a response; one more silent cycle halts.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             c_jal;
    logic             c_jalr;
    logic             c_branch;
    logic             c_trap;
    logic             c_store;
    logic             c_rd_wen;

    function automatic logic [2:0] pc_sel(input logic trap, input logic jalr,
                                          input logic jal, input logic branch);
        if (trap)        return 3'b101;
        else if (jalr)   return 3'b001;
        else if (jal)    return 3'b010;
        else if (branch) return 3'b100;
        else             return 3'b110;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            inst          <= '0;
            wait_cnt      <= '0;
            ifu_req_valid <= 1'b0;
            lsu_req_valid <= 1'b0;
            pc_single     <= 3'b000;
            in_valid      <= 1'b0;
            reg_wen       <= 1'b0;
            busy          <= 1'b0;
            halted        <= 1'b0;
            timeout_err   <= 1'b0;
            c_jal         <= 1'b0;
            c_jalr        <= 1'b0;
            c_branch      <= 1'b0;
            c_trap        <= 1'b0;
            c_store       <= 1'b0;
            c_rd_wen      <= 1'b0;
        end else begin
            // Commit outputs are single-cycle; only the WB entry paths raise them.
            in_valid  <= 1'b0;
            reg_wen   <= 1'b0;
            pc_single <= 3'b000;
            case (state)
                IDLE: begin
                    state         <= IF_REQ;
                    ifu_req_valid <= 1'b1;
                    busy          <= 1'b1;
                end
                IF_REQ: begin
                    if (ifu_req_ready) begin
                        state         <= IF_WAIT;
                        ifu_req_valid <= 1'b0;
                        wait_cnt      <= '0;
                    end
                end
                IF_WAIT: begin
                    if (ifu_rsp_valid) begin
                        state <= EX;
                        inst  <= ifu_rsp_data;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_LAST) begin
                            state       <= HALT;
                            busy        <= 1'b0;
                            halted      <= 1'b1;
                            timeout_err <= 1'b1;
                        end
                    end
                end
                EX: begin
                    c_jal    <= dec_jal;
                    c_jalr   <= dec_jalr;
                    c_branch <= dec_branch;
                    c_trap   <= dec_trap;
                    c_store  <= dec_store;
                    c_rd_wen <= dec_rd_wen;
                    if (dec_ebreak) begin
                        state  <= HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else if (dec_load || dec_store) begin
                        state         <= MEM_REQ;
                        lsu_req_valid <= 1'b1;
                    end else begin
                        state     <= WB;
                        in_valid  <= 1'b1;
                        reg_wen   <= dec_rd_wen & ~dec_store & ~dec_branch;
                        pc_single <= pc_sel(dec_trap, dec_jalr, dec_jal, dec_branch);
                    end
                end
                MEM_REQ: begin
                    if (lsu_req_ready) begin
                        state         <= MEM_WAIT;
                        lsu_req_valid <= 1'b0;
                        wait_cnt      <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (lsu_rsp_valid) begin
                        state     <= WB;
                        in_valid  <= 1'b1;
                        reg_wen   <= c_rd_wen & ~c_store & ~c_branch;
                        pc_single <= pc_sel(c_trap, c_jalr, c_jal, c_branch);
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_LAST) begin
                            state       <= HALT;
                            busy        <= 1'b0;
                            halted      <= 1'b1;
                            timeout_err <= 1'b1;
                        end
                    end
                end
                WB: begin
                    state         <= IF_REQ;
                    ifu_req_valid <= 1'b1;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Randomized bench for core_seq_ctrl: per-instruction outcome and latency come from
// instruction-class rules and bus delays, not from the sequencer's state machine.
module tb_core_seq_ctrl;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_rsp_data, inst;
    logic        dec_jal, dec_jalr, dec_branch, dec_trap, dec_load, dec_store, dec_ebreak, dec_rd_wen;
    logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
    logic [2:0]  pc_single;
    logic        in_valid, reg_wen, busy, halted, timeout_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_w;

    core_seq_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(10)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .inst(inst),
        .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_branch(dec_branch), .dec_trap(dec_trap),
        .dec_load(dec_load), .dec_store(dec_store), .dec_ebreak(dec_ebreak), .dec_rd_wen(dec_rd_wen),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
        .pc_single(pc_single), .in_valid(in_valid), .reg_wen(reg_wen),
        .busy(busy), .halted(halted), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Toy decoder: class flags live in the low byte of the latched instruction.
    assign dec_jal    = inst[0];
    assign dec_jalr   = inst[1];
    assign dec_branch = inst[2];
    assign dec_trap   = inst[3];
    assign dec_load   = inst[4];
    assign dec_store  = inst[5];
    assign dec_ebreak = inst[6];
    assign dec_rd_wen = inst[7];

    function automatic logic [31:0] mk_word(input logic jal, input logic jalr, input logic br,
                                            input logic trap, input logic ld, input logic st,
                                            input logic eb, input logic rd);
        logic [31:0] r;
        r = $urandom;
        return {r[31:8], rd, eb, st, ld, trap, br, jalr, jal};
    endfunction

    function automatic logic [2:0] exp_pc(input logic [31:0] w);
        if (w[3]) return 3'b101;
        if (w[1]) return 3'b001;
        if (w[0]) return 3'b010;
        if (w[2]) return 3'b100;
        return 3'b110;
    endfunction

    function automatic logic exp_wen(input logic [31:0] w);
        return w[7] & ~w[5] & ~w[2];
    endfunction

    function automatic int exp_lat(input logic [31:0] w, input int rdy, input int rsp,
                                   input int lrdy, input int lrsp);
        return 3 + rdy + rsp + ((w[4] | w[5]) ? 2 + lrdy + lrsp : 0);
    endfunction

    task automatic drive_idle();
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_data = '0;
        lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_w = '0;
    endtask

    // Plays the IFU/LSU for one instruction starting in the fetch-request phase; t counts
    // negedge samples from 0. viol counts protocol breaches seen along the way.
    task automatic run_instr(input logic [31:0] w, input int rdy_d, input int rsp_d,
                             input int lrdy_d, input int lrsp_d, input bit noise, input int max_cyc,
                             output int wb_t, output logic [2:0] pc_o, output logic wen_o,
                             output logic [31:0] inst_o, output int halt_t, output int rsp_t,
                             output int viol);
        int t, fph, fcnt, mph, mcnt;
        bit done;
        wb_t = -1; halt_t = -1; rsp_t = -1; viol = 0;
        pc_o = '0; wen_o = 1'b0; inst_o = '0;
        t = 0; fph = 0; fcnt = 0; mph = 0; mcnt = 0; done = 1'b0;
        while (!done && t < max_cyc) begin
            @(negedge clk);
            if (in_valid) begin
                wb_t = t; pc_o = pc_single; wen_o = reg_wen; inst_o = inst; done = 1'b1;
            end else begin
                if (pc_single !== 3'b000 || reg_wen !== 1'b0) viol++;
                if (halted) begin halt_t = t; done = 1'b1; end
            end
            if (fph == 0 && ifu_req_valid !== 1'b1) viol++;
            if (fph == 1 && ifu_req_valid !== 1'b0) viol++;
            if (fph == 2 ? inst !== w : inst !== last_w) viol++;
            if (mph == 1 && lsu_req_valid !== 1'b1) viol++;
            if (done) begin
                drive_idle();
            end else begin
                ifu_req_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                ifu_rsp_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                lsu_req_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                lsu_rsp_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                ifu_rsp_data  = $urandom;
                if (fph == 0) begin
                    if (fcnt >= rdy_d) begin ifu_req_ready = 1'b1; fph = 1; fcnt = 0; end
                    else begin ifu_req_ready = 1'b0; fcnt++; end
                end else if (fph == 1) begin
                    if (fcnt >= rsp_d) begin ifu_rsp_valid = 1'b1; ifu_rsp_data = w; fph = 2; end
                    else begin ifu_rsp_valid = 1'b0; fcnt++; end
                end
                if (mph == 0 && lsu_req_valid) begin mph = 1; mcnt = 0; end
                if (mph == 1) begin
                    if (mcnt >= lrdy_d) begin lsu_req_ready = 1'b1; mph = 2; mcnt = 0; end
                    else begin lsu_req_ready = 1'b0; mcnt++; end
                end else if (mph == 2) begin
                    if (mcnt >= lrsp_d) begin lsu_rsp_valid = 1'b1; mph = 3; rsp_t = t; end
                    else begin lsu_rsp_valid = 1'b0; mcnt++; end
                end
            end
            t++;
        end
        if (fph == 2) last_w = w;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        checks++;
        if ({ifu_req_valid, lsu_req_valid, in_valid, reg_wen, busy, halted, timeout_err, pc_single} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0", {ifu_req_valid, lsu_req_valid, in_valid,
                     reg_wen, busy, halted, timeout_err, pc_single});
        end
        checks++;
        if (inst !== 32'd0) begin errors++; $display("FAIL reset_inst: got %h required 0", inst); end
        rst = 1'b0;
        last_w = '0;
        @(negedge clk);
        checks++;
        if (ifu_req_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL req_cycle1: req=%b busy=%b required 1 1", ifu_req_valid, busy);
        end
    endtask

    task automatic test_alu();
        int wb_t, halt_t, rsp_t, viol;
        logic [2:0] pc; logic wen; logic [31:0] io, w;
        do_reset();
        w = mk_word(0, 0, 0, 0, 0, 0, 0, 1);
        run_instr(w, 0, 0, 0, 0, 0, 20, wb_t, pc, wen, io, halt_t, rsp_t, viol);
        checks++;
        if (wb_t !== 3 || pc !== 3'b110 || wen !== 1'b1 || io !== w || viol != 0) begin
            errors++;
            $display("FAIL addi_wb: wb_t=%0d pc=%b wen=%b inst=%h viol=%0d required 3 110 1 %h 0",
                     wb_t, pc, wen, io, viol, w);
        end
    endtask

    task automatic test_control_flow();
        logic [7:0] cls [6] = '{8'h81, 8'h82, 8'h84, 8'h88, 8'h89, 8'h83};
        logic [2:0] exp [6] = '{3'b010, 3'b001, 3'b100, 3'b101, 3'b101, 3'b001};
        logic       ewn [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int wb_t, halt_t, rsp_t, viol;
        logic [2:0] pc; logic wen; logic [31:0] io, w;
        for (int i = 0; i < 6; i++) begin
            w = {mk_word(0, 0, 0, 0, 0, 0, 0, 0) >> 8, cls[i]};
            run_instr(w, 0, 0, 0, 0, 0, 20, wb_t, pc, wen, io, halt_t, rsp_t, viol);
            checks++;
            if (pc !== exp[i] || wen !== ewn[i] || wb_t !== 3 || viol != 0) begin
                errors++;
                $display("FAIL ctrl_flow[%0d]: pc=%b wen=%b wb_t=%0d viol=%0d required %b %b 3 0",
                         i, pc, wen, wb_t, viol, exp[i], ewn[i]);
            end
        end
    endtask

    task automatic test_mem();
        int wb_t, halt_t, rsp_t, viol;
        logic [2:0] pc; logic wen; logic [31:0] io, w;
        w = mk_word(0, 0, 0, 0, 1, 0, 0, 1);
        run_instr(w, 0, 0, 0, 5, 0, 40, wb_t, pc, wen, io, halt_t, rsp_t, viol);
        checks++;
        if (wb_t !== rsp_t + 1 || wb_t !== 10 || wen !== 1'b1 || pc !== 3'b110 || viol != 0) begin
            errors++;
            $display("FAIL lw_delayed: wb_t=%0d rsp_t=%0d wen=%b pc=%b viol=%0d required 10 9 1 110 0",
                     wb_t, rsp_t, wen, pc, viol);
        end
        w = mk_word(0, 0, 0, 0, 0, 1, 0, 1);
        run_instr(w, 1, 2, 3, 1, 0, 40, wb_t, pc, wen, io, halt_t, rsp_t, viol);
        checks++;
        if (wb_t !== 12 || wen !== 1'b0 || pc !== 3'b110 || viol != 0) begin
            errors++;
            $display("FAIL sw_wb: wb_t=%0d wen=%b pc=%b viol=%0d required 12 0 110 0", wb_t, wen, pc, viol);
        end
    endtask

    task automatic test_back_to_back();
        int wb_t, halt_t, rsp_t, viol, rd, rs, lr, lp, kind;
        logic [2:0] pc; logic wen; logic [31:0] io, w;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            w = mk_word(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), kind == 1, kind == 2, 1'b0, 1'($urandom_range(0, 1)));
            rd = $urandom_range(0, 3); rs = $urandom_range(0, 5);
            lr = $urandom_range(0, 3); lp = $urandom_range(0, 5);
            run_instr(w, rd, rs, lr, lp, 1, 60, wb_t, pc, wen, io, halt_t, rsp_t, viol);
            checks++;
            if (wb_t !== exp_lat(w, rd, rs, lr, lp) || pc !== exp_pc(w) || wen !== exp_wen(w) ||
                io !== w || viol != 0) begin
                errors++;
                $display("FAIL random[%0d] w=%h: wb_t=%0d pc=%b wen=%b inst=%h viol=%0d required %0d %b %b %h 0",
                         i, w, wb_t, pc, wen, io, viol, exp_lat(w, rd, rs, lr, lp), exp_pc(w), exp_wen(w), w);
            end
        end
    endtask

    task automatic test_ebreak();
        int wb_t, halt_t, rsp_t, viol;
        logic [2:0] pc; logic wen; logic [31:0] io, w;
        w = mk_word(0, 0, 0, 0, 0, 0, 1, 1);
        run_instr(w, 2, 1, 0, 0, 0, 30, wb_t, pc, wen, io, halt_t, rsp_t, viol);
        checks++;
        if (halt_t !== 6 || wb_t !== -1 || viol != 0 || timeout_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ebreak_halt: halt_t=%0d wb_t=%0d viol=%0d terr=%b busy=%b required 6 -1 0 0 0",
                     halt_t, wb_t, viol, timeout_err, busy);
        end
        for (int i = 0; i < 5; i++) begin
            ifu_req_ready = 1'($urandom_range(0, 1)); ifu_rsp_valid = 1'($urandom_range(0, 1));
            lsu_req_ready = 1'($urandom_range(0, 1)); lsu_rsp_valid = 1'($urandom_range(0, 1));
            ifu_rsp_data = $urandom;
            @(negedge clk);
            checks++;
            if ({halted, busy, ifu_req_valid, lsu_req_valid, in_valid, pc_single} !== 8'b1000_0000 || inst !== w) begin
                errors++;
                $display("FAIL halt_absorb[%0d]: got %b inst=%h required 10000000 %h", i,
                         {halted, busy, ifu_req_valid, lsu_req_valid, in_valid, pc_single}, inst, w);
            end
        end
    endtask

    task automatic test_timeout();
        int wb_t, halt_t, rsp_t, viol;
        logic [2:0] pc; logic wen; logic [31:0] io, w;
        do_reset();
        checks++;
        if (timeout_err !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_cleared_by_rst: terr=%b halted=%b required 0 0", timeout_err, halted);
        end
        w = mk_word(0, 0, 0, 0, 0, 0, 0, 1);
        run_instr(w, 0, 1000, 0, 0, 0, 30, wb_t, pc, wen, io, halt_t, rsp_t, viol);
        checks++;
        if (halt_t !== 1 + TMO || timeout_err !== 1'b1 || wb_t !== -1 || viol != 0) begin
            errors++;
            $display("FAIL fetch_timeout: halt_t=%0d terr=%b wb_t=%0d viol=%0d required %0d 1 -1 0",
                     halt_t, timeout_err, wb_t, viol, 1 + TMO);
        end
        do_reset();
        w = mk_word(0, 0, 0, 0, 1, 0, 0, 1);
        run_instr(w, 1, 0, 2, 1000, 0, 40, wb_t, pc, wen, io, halt_t, rsp_t, viol);
        checks++;
        if (halt_t !== 4 + 1 + 2 + TMO || timeout_err !== 1'b1 || wb_t !== -1 || viol != 0) begin
            errors++;
            $display("FAIL mem_timeout: halt_t=%0d terr=%b wb_t=%0d viol=%0d required %0d 1 -1 0",
                     halt_t, timeout_err, wb_t, viol, 4 + 1 + 2 + TMO);
        end
    endtask

    task automatic test_rst_mid();
        int wb_t, halt_t, rsp_t, viol;
        logic [2:0] pc; logic wen; logic [31:0] io, w;
        do_reset();
        w = mk_word(0, 0, 0, 0, 1, 0, 0, 1);
        run_instr(w, 0, 0, 0, 5, 0, 5, wb_t, pc, wen, io, halt_t, rsp_t, viol);
        checks++;
        if (busy !== 1'b1 || lsu_req_valid !== 1'b0 || wb_t !== -1 || viol != 0) begin
            errors++;
            $display("FAIL in_mem_wait: busy=%b lreq=%b wb_t=%0d viol=%0d required 1 0 -1 0",
                     busy, lsu_req_valid, wb_t, viol);
        end
        rst = 1'b1;
        lsu_rsp_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, in_valid, reg_wen, lsu_req_valid, ifu_req_valid, halted, pc_single} !== 9'd0 || inst !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_idle: got %b inst=%h required 0 0",
                     {busy, in_valid, reg_wen, lsu_req_valid, ifu_req_valid, halted, pc_single}, inst);
        end
        rst = 1'b0;
        drive_idle();
        last_w = '0;
        @(negedge clk);
        checks++;
        if (ifu_req_valid !== 1'b1 || in_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_restart: req=%b in_valid=%b required 1 0", ifu_req_valid, in_valid);
        end
        w = mk_word(1, 0, 0, 0, 0, 0, 0, 1);
        run_instr(w, 4, 0, 0, 0, 1, 30, wb_t, pc, wen, io, halt_t, rsp_t, viol);
        checks++;
        if (wb_t !== 7 || pc !== 3'b010 || wen !== 1'b1 || io !== w || viol != 0) begin
            errors++;
            $display("FAIL held_req_jal: wb_t=%0d pc=%b wen=%b inst=%h viol=%0d required 7 010 1 %h 0",
                     wb_t, pc, wen, io, viol, w);
        end
    endtask

    initial begin
        rst = 1'b1;
        last_w = '0;
        drive_idle();
        test_reset();
        test_alu();
        test_control_flow();
        test_mem();
        test_back_to_back();
        test_ebreak();
        test_timeout();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
